// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  // Length header is two bytes (little-endian word count).
  localparam int HDR_BYTES      = 2;
  // Instruction words are assembled from four bytes, LSB first.
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Shifts incoming bytes into a little-endian word and flags the byte that
// completes it. The merged word is presented combinationally so the write
// can be launched on the same edge the last byte is accepted.
module word_assembler
  import loader_pkg::*;
#(
  parameter int data_bits = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [7:0]           byte_in,
  output logic [data_bits-1:0] word,
  output logic                 word_ready
);

  logic [data_bits-1:0] word_q;
  logic [1:0]           byte_cnt_q;

  // Merge the current byte into its lane of the partially built word.
  always_comb begin
    word = word_q;
    if (shift_en) begin
      word[{byte_cnt_q, 3'b000} +: 8] = byte_in;
    end
    word_ready = shift_en && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
  end

  // Byte position within the word; wraps naturally after the fourth byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
    end else if (clear) begin
      byte_cnt_q <= '0;
    end else if (shift_en) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

  // Word storage; every lane is rewritten before the next word completes.
  always_ff @(posedge clk) begin
    if (clear) begin
      word_q <= '0;
    end else if (shift_en) begin
      word_q <= word;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: parses a length-prefixed byte stream, writes the
// assembled words into instruction memory from address 0, verifies an XOR
// checksum and releases the core from reset only after a clean load.
module program_loader
  import loader_pkg::*;
#(
  parameter int data_bits           = 32,
  parameter int memory_size         = 1024,
  parameter int memory_address_bits = $clog2(memory_size)
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           start,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic                           rx_ready,
  output logic                           imem_wr_en,
  output logic [memory_address_bits-1:0] imem_addr,
  output logic [data_bits-1:0]           imem_wr_data,
  output logic                           core_reset_n,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

  localparam int LEN_W = HDR_BYTES * 8;
  // One extra bit so the index can reach memory_size on the last word.
  localparam int IDX_W = memory_address_bits + 1;
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(memory_size);

  loader_state_t        state_q, state_d;
  logic [7:0]           len_lo_q;
  logic [LEN_W-1:0]     n_q;
  logic [LEN_W-1:0]     n_rx;
  logic [IDX_W-1:0]     idx_q;
  logic [7:0]           acc_q;
  logic                 accept;
  logic                 load_start;
  logic                 shift_en;
  logic                 word_ready;
  logic [data_bits-1:0] asm_word;

  assign accept     = rx_valid && rx_ready;
  assign load_start = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign shift_en   = accept && (state_q == DATA);
  assign n_rx       = {rx_data, len_lo_q};

  word_assembler #(
    .data_bits (data_bits)
  ) u_word_assembler (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .clear      (load_start),
    .shift_en   (shift_en),
    .byte_in    (rx_data),
    .word       (asm_word),
    .word_ready (word_ready)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every byte-consuming state advances only on accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (load_start) state_d = LEN0;
      LEN0:              if (accept) state_d = LEN1;
      LEN1: begin
        if (accept) begin
          if (n_rx == '0 || {1'b0, n_rx} > MAX_WORDS) state_d = ERROR;
          else                                        state_d = DATA;
        end
      end
      DATA:              if (word_ready) state_d = WRITE;
      WRITE:             state_d = (LEN_W'(idx_q + 1'b1) == n_q) ? CHECK : DATA;
      CHECK: begin
        if (accept) state_d = (rx_data == acc_q) ? DONE : ERROR;
      end
      default:           state_d = IDLE;
    endcase
  end

  // Word index: cleared at load start, advanced once per memory write.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q <= '0;
    end else if (load_start) begin
      idx_q <= '0;
    end else if (state_q == WRITE) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Header bytes and running payload checksum.
  always_ff @(posedge CLK) begin
    if (accept && state_q == LEN0) len_lo_q <= rx_data;
    if (accept && state_q == LEN1) n_q <= n_rx;
    if (load_start)    acc_q <= '0;
    else if (shift_en) acc_q <= acc_q ^ rx_data;
  end

  // Registered outputs decoded from the state being entered, so they are
  // valid in the same cycle the FSM occupies that state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_ready     <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_addr    <= '0;
      imem_wr_data <= '0;
      core_reset_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      rx_ready     <= (state_d == LEN0) || (state_d == LEN1) ||
                      (state_d == DATA) || (state_d == CHECK);
      busy         <= (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA) ||
                      (state_d == WRITE) || (state_d == CHECK);
      imem_wr_en   <= (state_d == WRITE);
      core_reset_n <= (state_d == DONE);
      done         <= (state_d == DONE);
      error        <= (state_d == ERROR);
      if (state_d == WRITE) begin
        imem_addr    <= idx_q[memory_address_bits-1:0];
        imem_wr_data <= asm_word;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed vector table, hand-written reset
// and restart sequences, and randomized streams against a stream-level model.
module tb_program_loader;
  import loader_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_wr_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wr_data;
  logic        core_reset_n;
  logic        busy;
  logic        done;
  logic        error;

  program_loader #(
    .data_bits   (32),
    .memory_size (1024)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_addr    (imem_addr),
    .imem_wr_data (imem_wr_data),
    .core_reset_n (core_reset_n),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc++;

  logic [7:0]  stream    [0:63];
  logic [31:0] exp_words [0:15];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];

  // Write monitor.
  always @(negedge CLK) begin
    if (imem_wr_en) begin
      wr_addr_q.push_back(32'(imem_addr));
      wr_data_q.push_back(imem_wr_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},     32'(rx_ready),     0);
    check({tag, "_imem_wr_en"},   32'(imem_wr_en),   0);
    check({tag, "_imem_addr"},    32'(imem_addr),    0);
    check({tag, "_imem_wr_data"}, imem_wr_data,      0);
    check({tag, "_core_reset_n"}, 32'(core_reset_n), 0);
    check({tag, "_busy"},         32'(busy),         0);
    check({tag, "_done"},         32'(done),         0);
    check({tag, "_error"},        32'(error),        0);
    check({tag, "_state"},        32'(dut.state_q),  32'(IDLE));
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check({tag, "_busy_after_start"},  32'(busy),     1);
    check({tag, "_ready_after_start"}, 32'(rx_ready), 1);
  endtask

  // Drive stream[first..last-1]; check write latency after each word's 4th byte.
  task automatic send_stream(input int first, input int last, input int gap, input int nwr);
    for (int i = first; i < last; i++) begin
      int w = 0;
      rx_data  = stream[i];
      rx_valid = 1'b1;
      while (!rx_ready && w < 50) begin
        @(negedge CLK);
        w++;
      end
      if (!rx_ready) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout byte %0d: rx_ready still 0 after %0d cycles, required 1", i, w);
        rx_valid = 1'b0;
        return;
      end
      @(negedge CLK);
      if (i >= 2 && i < 2 + 4 * nwr && ((i - 2) % 4) == 3) begin
        check("wr_en_latency", 32'(imem_wr_en), 1);
        check("wr_addr_latency", 32'(imem_addr), 32'((i - 2) / 4));
      end
      if (gap > 0 || i == last - 1) begin
        rx_valid = 1'b0;
        repeat (gap) @(negedge CLK);
      end
    end
  endtask

  task automatic check_outcome(input string tag, input logic exp_done, input logic exp_err);
    check({tag, "_done"},         32'(done),         32'(exp_done));
    check({tag, "_error"},        32'(error),        32'(exp_err));
    check({tag, "_core_reset_n"}, 32'(core_reset_n), 32'(exp_done));
    check({tag, "_busy"},         32'(busy),         0);
    check({tag, "_rx_ready"},     32'(rx_ready),     0);
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(n));
    for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
      check({tag, "_wr_addr"}, wr_addr_q[k], 32'(k));
      check({tag, "_wr_data"}, wr_data_q[k], exp_words[k]);
    end
  endtask

  // Reference model: interprets the byte stream by the protocol rules.
  function automatic void model(output logic d, output logic e, output int nwr, output int len);
    int n;
    logic [7:0] x;
    n = int'({stream[1], stream[0]});
    x = 8'h00;
    if (n == 0 || n > 1024) begin
      d = 1'b0; e = 1'b1; nwr = 0; len = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_words[k] = {stream[2+4*k+3], stream[2+4*k+2], stream[2+4*k+1], stream[2+4*k]};
      for (int b = 0; b < 4; b++) x = x ^ stream[2+4*k+b];
    end
    nwr = n;
    len = 2 + 4 * n + 1;
    d   = (stream[2+4*n] == x);
    e   = !d;
  endfunction

  typedef struct {
    logic [7:0] len_lo;
    logic [7:0] len_hi;
    int         has_payload;
    int         gap;
    logic [7:0] chk;
    logic       exp_done;
    logic       exp_err;
    int         exp_nwr;
  } vec_t;

  vec_t       tbl [0:4];
  logic [7:0] good_pl [0:7];

  task automatic load_good_stream();
    stream[0] = 8'h02;
    stream[1] = 8'h00;
    for (int b = 0; b < 8; b++) stream[2+b] = good_pl[b];
    stream[10] = 8'h41;
    exp_words[0] = 32'h00500093;
    exp_words[1] = 32'h00108113;
  endtask

  initial begin
    int slen;
    logic md, me;
    int mn, ml;

    good_pl = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00};
    tbl[0] = '{8'h02, 8'h00, 1, 0, 8'h41, 1'b1, 1'b0, 2};
    tbl[1] = '{8'h02, 8'h00, 1, 3, 8'h41, 1'b1, 1'b0, 2};
    tbl[2] = '{8'h02, 8'h00, 1, 0, 8'h40, 1'b0, 1'b1, 2};
    tbl[3] = '{8'h00, 8'h00, 0, 0, 8'h00, 1'b0, 1'b1, 0};
    tbl[4] = '{8'h01, 8'h04, 0, 0, 8'h00, 1'b0, 1'b1, 0};

    RESET_N  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    check_reset_vals("reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check_reset_vals("idle_after_reset");

    // Directed vectors.
    for (int r = 0; r < 5; r++) begin
      stream[0] = tbl[r].len_lo;
      stream[1] = tbl[r].len_hi;
      slen = 2;
      if (tbl[r].has_payload != 0) begin
        for (int b = 0; b < 8; b++) stream[2+b] = good_pl[b];
        stream[10] = tbl[r].chk;
        slen = 11;
      end
      exp_words[0] = 32'h00500093;
      exp_words[1] = 32'h00108113;
      clear_writes();
      pulse_start($sformatf("vec%0d", r));
      send_stream(0, slen, tbl[r].gap, tbl[r].exp_nwr);
      check_outcome($sformatf("vec%0d", r), tbl[r].exp_done, tbl[r].exp_err);
      check_writes($sformatf("vec%0d", r), tbl[r].exp_nwr);
      if (r == 0 && wr_cyc_q.size() == 2) begin
        check("throughput_cycles", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 5);
      end
    end

    // Reset mid-load after 6 bytes, then a full restart.
    load_good_stream();
    clear_writes();
    pulse_start("midreset");
    send_stream(0, 6, 0, 2);
    RESET_N = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    clear_writes();
    pulse_start("restart");
    send_stream(0, 11, 0, 2);
    check_outcome("restart", 1'b1, 1'b0);
    check_writes("restart", 2);

    // start asserted mid-load is ignored.
    clear_writes();
    pulse_start("ignstart");
    send_stream(0, 4, 0, 2);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("ignstart_busy", 32'(busy), 1);
    check("ignstart_ready", 32'(rx_ready), 1);
    send_stream(4, 11, 1, 2);
    check_outcome("ignstart", 1'b1, 1'b0);
    check_writes("ignstart", 2);

    // Randomized streams against the model.
    for (int r = 0; r < 25; r++) begin
      int n;
      int gap;
      logic [7:0] x;
      gap = int'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0:       n = 0;
          1:       n = 1025 + int'($urandom_range(0, 1000));
          default: n = 65535;
        endcase
      end else begin
        n = int'($urandom_range(1, 6));
      end
      stream[0] = 8'(n);
      stream[1] = 8'(n >> 8);
      if (n >= 1 && n <= 6) begin
        x = 8'h00;
        for (int b = 0; b < 4 * n; b++) begin
          stream[2+b] = 8'($urandom);
          x = x ^ stream[2+b];
        end
        stream[2+4*n] = x;
        if ($urandom_range(0, 2) == 0) stream[2+4*n] = x ^ 8'($urandom_range(1, 255));
      end
      model(md, me, mn, ml);
      clear_writes();
      pulse_start($sformatf("rnd%0d", r));
      send_stream(0, ml, gap, mn);
      check_outcome($sformatf("rnd%0d", r), md, me);
      check_writes($sformatf("rnd%0d", r), mn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits directly upstream of the core's instruction memory and feeds it. It accepts a byte stream over a valid/ready handshake and checks a length header. It assembles little-endian 32-bit words, writes them sequentially into instruction memory from word address 0, and verifies an XOR checksum. The core is held in reset until a load completes successfully.

## Interface
- data_bits, 32, instruction word width; fixed at 32 for this protocol.
- memory_size, 1024, instruction memory depth in words.
- memory_address_bits, $clog2(memory_size), word-address width.
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle pulse that begins a load; ignored while busy.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- imem_wr_en  out  1  instruction-memory write strobe.
- imem_addr  out  memory_address_bits  word address of the write.
- imem_wr_data  out  data_bits  assembled word.
- core_reset_n  out  1  active-low reset to the core; high only in DONE.
- busy  out  1  load in progress.
- done  out  1  last load succeeded.
- error  out  1  last load failed.

## Operation
- Stream format:
  - LEN_LO byte, then LEN_HI byte, forming the word count N (16-bit).
  - N×4 payload bytes, each word least-significant byte first.
  - One checksum byte, equal to the XOR of all payload bytes only.
- A byte is accepted on a rising edge where rx_valid && rx_ready.
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, CHECK, DONE, ERROR.
  - IDLE/DONE/ERROR, on start: go to LEN0. Clear the word index, byte counter and XOR accumulator. Clear done and error. Drive core_reset_n=0.
  - LEN0, on accept: latch the low byte, go to LEN1.
  - LEN1, on accept: form N.
    - If N==0 or N>memory_size, go to ERROR.
    - Otherwise go to DATA.
  - DATA, on accept: shift the byte into the word at position byte_cnt and XOR it into the accumulator. When the 4th byte is accepted, go to WRITE.
  - WRITE, exactly one cycle: imem_wr_en=1, imem_addr=word index, imem_wr_data=assembled word. Then increment the index.
    - If the incremented index equals N, go to CHECK.
    - Otherwise go to DATA.
  - CHECK, on accept: if the byte equals the accumulator, go to DONE; otherwise go to ERROR.
- rx_ready=1 only in LEN0, LEN1, DATA and CHECK. It is 0 in WRITE, IDLE, DONE and ERROR.
- busy=1 in LEN0 through CHECK.
- done=1 only in DONE; error=1 only in ERROR.
- core_reset_n=1 only in DONE.
- Words already written before an error stay in memory. The core stays in reset.
- start while busy is ignored.

## Timing
- All outputs are registered and decoded from state.
- Reset values: rx_ready=0, imem_wr_en=0, imem_addr=0, imem_wr_data=0, core_reset_n=0, busy=0, done=0, error=0, state=IDLE.
- Write latency: 4th byte of word k accepted at edge t → imem_wr_en high for the cycle t..t+1 with imem_addr=k. The memory captures the word at edge t+1.
- Throughput: 5 cycles per word with rx_valid held high.
- Stalls: rx_valid low stalls indefinitely with no timeout, and all state is held.
- Completion: checksum byte accepted at edge t → done=1 and core_reset_n=1 from t.
- Asynchronous RESET_N mid-load returns immediately to reset values. Memory contents are not cleared.
- imem_addr wraps never: N≤memory_size is guaranteed by the LEN1 check.

## Structure
- loader_pkg holds:
  - the state enum loader_state_t;
  - constants HDR_BYTES=2 and BYTES_PER_WORD=4.
- One sub-module, word_assembler: byte shift-in, 2-bit byte counter, word_ready flag, clear input.
- The FSM, index counter and XOR accumulator live in program_loader.

## Test plan
- Reset values: assert RESET_N=0 → all outputs 0 and state IDLE.
- Good load:
  - Stimulus: start, then bytes 02 00 93 00 50 00 13 81 10 00 41 with rx_valid held high.
  - Required response:
    - writes addr0=0x00500093 and addr1=0x00108113, imem_wr_en high for exactly 2 cycles;
    - then done=1, core_reset_n=1, error=0.
- Stalled load: same stream with rx_valid dropped for 3 cycles between every byte → identical writes and DONE, and no byte is accepted while rx_valid=0.
- Bad checksum: same stream with the final byte 0x40 → both words written, then error=1, core_reset_n=0.
- Bad length:
  - Header 00 00 → ERROR after LEN1, no writes.
  - Header 01 04 (1025 words, one more than memory_size) → ERROR after LEN1, no writes.
- Reset and restart:
  - RESET_N pulsed low after 6 bytes → outputs return to reset values immediately.
  - A subsequent start plus the full good-load stream → DONE.
  - start asserted mid-load → ignored.
